// File: rtl/ecc_rmw_encoder.sv
// ecc_rmw_encoder
//   SECDED front end between a user request port and one block-RAM port.
//   Full writes are encoded and issued directly, one per cycle. Reads and
//   partial (bitmasked) writes read the stored codeword, decode and correct it,
//   and then either return the data or merge, re-encode and write it back.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake (accept on valid & ready)
//   req_we_i              1 = write, 0 = read
//   req_addr_i/data_i     request address and write data
//   req_mask_i            per-bit write enable (1 = bit is written)
//   ram_en_o/we_o         registered SRAM enable / write enable
//   ram_addr_o/data_o     registered SRAM address / codeword {chk, data}
//   ram_rdata_i           SRAM read codeword, valid RD_LAT cycles after ram_en_o
//   rd_valid_o/rd_data_o  one-cycle read response with corrected data
//   sec_err_o/ded_err_o   single-error-corrected / double-error-detected pulses
//   sec_cnt_o             saturating count of corrected errors
//
// Codeword layout: Hamming positions 1..DATA_W+CHK_W-1, check bit chk[i] sits at
// position 2**i, data bits fill the remaining positions in ascending order, and
// chk[CHK_W-1] is even parity over the whole codeword.

module ecc_rmw_encoder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CHK_W  = 7,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [ADDR_W-1:0]        req_addr_i,
    input  logic [DATA_W-1:0]        req_data_i,
    input  logic [DATA_W-1:0]        req_mask_i,
    output logic                     ram_en_o,
    output logic                     ram_we_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    output logic [DATA_W+CHK_W-1:0]  ram_data_o,
    input  logic [DATA_W+CHK_W-1:0]  ram_rdata_i,
    output logic                     rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     sec_err_o,
    output logic                     ded_err_o,
    output logic [15:0]              sec_cnt_o
);

    localparam int unsigned CW    = DATA_W + CHK_W;
    localparam int unsigned NP    = CHK_W - 1;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {StIdle, StRdIssue, StRdWait, StMerge, StWr} state_e;

    // Hamming check bits (without overall parity) for a data word.
    function automatic logic [NP-1:0] f_parity(input logic [DATA_W-1:0] d);
        logic [NP-1:0] p;
        int unsigned   di;
        p  = '0;
        di = 0;
        for (int unsigned pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int unsigned i = 0; i < NP; i++) begin
                    if (((pos >> i) & 1) != 0) begin
                        p[i] = p[i] ^ d[di];
                    end
                end
                di++;
            end
        end
        return p;
    endfunction

    function automatic logic [CW-1:0] f_encode(input logic [DATA_W-1:0] d);
        logic [NP-1:0] p;
        p = f_parity(d);
        return {^{p, d}, p, d};
    endfunction

    // Data-bit flip mask for a syndrome; zero when the syndrome names a check bit,
    // position 0 or a position beyond the codeword.
    function automatic logic [DATA_W-1:0] f_flip(input logic [NP-1:0] syn);
        logic [DATA_W-1:0] m;
        logic [31:0]       s;
        int unsigned       di;
        m  = '0;
        s  = 32'(syn);
        di = 0;
        for (int unsigned pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (pos == s) begin
                    m[di] = 1'b1;
                end
                di++;
            end
        end
        return m;
    endfunction

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_lat_cnt, w_lat_cnt_d;
    logic                r_req_we, w_req_we_d;
    logic [ADDR_W-1:0]   r_req_addr, w_req_addr_d;
    logic [DATA_W-1:0]   r_req_data, w_req_data_d;
    logic [DATA_W-1:0]   r_req_mask, w_req_mask_d;
    logic [CW-1:0]       r_rd_cw, w_rd_cw_d;
    logic                r_ram_en, w_ram_en_d;
    logic                r_ram_we, w_ram_we_d;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_d;
    logic [CW-1:0]       r_ram_data, w_ram_data_d;
    logic [15:0]         r_sec_cnt, w_sec_cnt_d;

    logic [NP-1:0]       w_syn;
    logic                w_par_bad;
    logic                w_ded;
    logic [DATA_W-1:0]   w_corr;
    logic [DATA_W-1:0]   w_merged;
    logic                w_in_merge;

    // Decode of the captured read codeword.
    always_comb begin
        w_syn      = f_parity(r_rd_cw[DATA_W-1:0]) ^ r_rd_cw[DATA_W +: NP];
        w_par_bad  = ^r_rd_cw;
        w_ded      = !w_par_bad && (w_syn != '0);
        // A bad overall parity means a single error; a zero syndrome then points
        // at the parity bit itself, so f_flip leaves the data alone.
        w_corr     = r_rd_cw[DATA_W-1:0] ^ (w_par_bad ? f_flip(w_syn) : '0);
        w_merged   = (r_req_data & r_req_mask) | (w_corr & ~r_req_mask);
        w_in_merge = (r_state == StMerge);
    end

    always_comb begin
        w_state_d    = r_state;
        w_lat_cnt_d  = r_lat_cnt;
        w_req_we_d   = r_req_we;
        w_req_addr_d = r_req_addr;
        w_req_data_d = r_req_data;
        w_req_mask_d = r_req_mask;
        w_rd_cw_d    = r_rd_cw;
        w_ram_en_d   = 1'b0;
        w_ram_we_d   = 1'b0;
        w_ram_addr_d = r_ram_addr;
        w_ram_data_d = r_ram_data;
        w_sec_cnt_d  = r_sec_cnt;

        unique case (r_state)
            StIdle: begin
                if (req_valid_i) begin
                    if (req_we_i && (&req_mask_i)) begin
                        w_ram_en_d   = 1'b1;
                        w_ram_we_d   = 1'b1;
                        w_ram_addr_d = req_addr_i;
                        w_ram_data_d = f_encode(req_data_i);
                    end else if (req_we_i && (req_mask_i == '0)) begin
                        // Nothing to write: accept and drop.
                    end else begin
                        w_req_we_d   = req_we_i;
                        w_req_addr_d = req_addr_i;
                        w_req_data_d = req_data_i;
                        w_req_mask_d = req_mask_i;
                        w_ram_en_d   = 1'b1;
                        w_ram_addr_d = req_addr_i;
                        w_state_d    = StRdIssue;
                    end
                end
            end
            StRdIssue: begin
                w_lat_cnt_d = '0;
                w_state_d   = StRdWait;
            end
            StRdWait: begin
                if (r_lat_cnt == CNT_W'(RD_LAT - 1)) begin
                    w_rd_cw_d = ram_rdata_i;
                    w_state_d = StMerge;
                end else begin
                    w_lat_cnt_d = r_lat_cnt + 1'b1;
                end
            end
            StMerge: begin
                if (w_par_bad && (r_sec_cnt != 16'hFFFF)) begin
                    w_sec_cnt_d = r_sec_cnt + 16'd1;
                end
                // Uncorrectable data is never written back.
                if (r_req_we && !w_ded) begin
                    w_ram_en_d   = 1'b1;
                    w_ram_we_d   = 1'b1;
                    w_ram_addr_d = r_req_addr;
                    w_ram_data_d = f_encode(w_merged);
                    w_state_d    = StWr;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StWr: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_lat_cnt  <= '0;
            r_req_we   <= 1'b0;
            r_req_addr <= '0;
            r_req_data <= '0;
            r_req_mask <= '0;
            r_rd_cw    <= '0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_sec_cnt  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_lat_cnt  <= w_lat_cnt_d;
            r_req_we   <= w_req_we_d;
            r_req_addr <= w_req_addr_d;
            r_req_data <= w_req_data_d;
            r_req_mask <= w_req_mask_d;
            r_rd_cw    <= w_rd_cw_d;
            r_ram_en   <= w_ram_en_d;
            r_ram_we   <= w_ram_we_d;
            r_ram_addr <= w_ram_addr_d;
            r_ram_data <= w_ram_data_d;
            r_sec_cnt  <= w_sec_cnt_d;
        end
    end

    // Ready is held low while reset is asserted.
    assign req_ready_o = (r_state == StIdle) && !rst_i;
    assign ram_en_o    = r_ram_en;
    assign ram_we_o    = r_ram_we;
    assign ram_addr_o  = r_ram_addr;
    assign ram_data_o  = r_ram_data;
    assign rd_valid_o  = w_in_merge && !r_req_we;
    assign rd_data_o   = rd_valid_o ? w_corr : '0;
    assign sec_err_o   = w_in_merge && w_par_bad;
    assign ded_err_o   = w_in_merge && w_ded;
    assign sec_cnt_o   = r_sec_cnt;

endmodule

// File: tb/tb_ecc_rmw_encoder.sv
// tb_ecc_rmw_encoder
//   Directed bench for ecc_rmw_encoder (default parameters, RD_LAT = 1) with a
//   behavioural SRAM. Read-path corruption is injected through an XOR mask on
//   ram_rdata_i.

module tb_ecc_rmw_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] req_mask;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [38:0] ram_data;
    logic [38:0] ram_rdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        sec_err;
    logic        ded_err;
    logic [15:0] sec_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int wr_cnt  = 0;
    int wcnt0;

    logic [38:0] mem [0:255];
    logic [38:0] rd_q = '0;
    logic [38:0] flip = '0;

    always #5 clk = ~clk;

    ecc_rmw_encoder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_mask_i  (req_mask),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_data),
        .ram_rdata_i (ram_rdata),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .sec_err_o   (sec_err),
        .ded_err_o   (ded_err),
        .sec_cnt_o   (sec_cnt)
    );

    // One-cycle-latency SRAM.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr[7:0]] <= ram_data;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_q <= mem[ram_addr[7:0]];
            end
        end
    end

    assign ram_rdata = rd_q ^ flip;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Syndrome as the XOR of the positions of all set bits.
    function automatic logic [5:0] tb_syn(input logic [38:0] cw);
        int         di;
        int         pi;
        logic [5:0] s;
        logic       b;
        di = 0;
        pi = 0;
        s  = '0;
        for (int pos = 1; pos < 39; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                b = cw[32 + pi];
                pi++;
            end else begin
                b = cw[di];
                di++;
            end
            if (b) s = s ^ pos[5:0];
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                           input logic [31:0] m);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
    endtask

    // Issue a read / partial write and advance to its MERGE cycle (N+3).
    task automatic run_rmw(input logic we, input logic [15:0] a, input logic [31:0] d,
                           input logic [31:0] m);
        set_req(we, a, d, m);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 64'({req_ready, ram_en, ram_we, rd_valid, sec_err, ded_err}), 64'd0);
        check_eq({tag, " bus"}, 64'({ram_addr, sec_cnt}), 64'd0);
        check_eq({tag, " data"}, 64'(ram_data), 64'd0);
        check_eq({tag, " rdata"}, 64'(rd_data), 64'd0);
    endtask

    logic [31:0] bd [4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h8000_0000};
    logic [38:0] bc [4] = '{{7'h43, 32'h0000_0001}, {7'h45, 32'h0000_0002},
                            {7'h06, 32'h0000_0003}, {7'h26, 32'h8000_0000}};

    initial begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_mask  = '0;

        // Reset
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check_eq("ready after reset", 64'(req_ready), 64'd1);

        // Back-to-back full writes with hand-computed codewords
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 16'(i), bd[i], '1);
            tick();
            check_eq($sformatf("b2b%0d en/we", i), 64'({ram_en, ram_we}), 64'd3);
            check_eq($sformatf("b2b%0d addr", i), 64'(ram_addr), 64'(i));
            check_eq($sformatf("b2b%0d cw", i), 64'(ram_data), 64'(bc[i]));
        end
        req_valid = 1'b0;
        tick();
        check_eq("b2b idle en", 64'(ram_en), 64'd0);

        // Mask all zeros: accepted, no SRAM access
        wcnt0 = wr_cnt;
        set_req(1'b1, 16'd9, 32'h0000_FFFF, 32'h0);
        tick();
        req_valid = 1'b0;
        check_eq("mask0 en", 64'(ram_en), 64'd0);
        check_eq("mask0 ready", 64'(req_ready), 64'd1);
        tick();
        check_eq("mask0 wr_cnt", 64'(wr_cnt), 64'(wcnt0));

        // Full write DEADBEEF @5
        set_req(1'b1, 16'd5, 32'hDEAD_BEEF, '1);
        tick();
        req_valid = 1'b0;
        check_eq("fw en/we", 64'({ram_en, ram_we}), 64'd3);
        check_eq("fw addr", 64'(ram_addr), 64'd5);
        check_eq("fw data", 64'(ram_data[31:0]), 64'h0000_0000_DEAD_BEEF);
        check_eq("fw syn", 64'(tb_syn(ram_data)), 64'd0);
        check_eq("fw par", 64'(^ram_data), 64'd0);

        // Store 12345678 @7, then partial write AA / FF
        set_req(1'b1, 16'd7, 32'h1234_5678, '1);
        tick();
        req_valid = 1'b0;
        tick();
        set_req(1'b1, 16'd7, 32'h0000_00AA, 32'h0000_00FF);
        check_eq("pw ready N", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check_eq("pw N+1 en/we", 64'({ram_en, ram_we}), 64'd2);
        check_eq("pw N+1 addr", 64'(ram_addr), 64'd7);
        check_eq("pw N+1 ready", 64'(req_ready), 64'd0);
        tick();
        check_eq("pw N+2 ready/en", 64'({req_ready, ram_en}), 64'd0);
        tick();
        check_eq("pw N+3 ready/en/err", 64'({req_ready, ram_en, sec_err, ded_err}), 64'd0);
        tick();
        check_eq("pw N+4 en/we", 64'({ram_en, ram_we}), 64'd3);
        check_eq("pw N+4 addr", 64'(ram_addr), 64'd7);
        check_eq("pw N+4 data", 64'(ram_data[31:0]), 64'h0000_0000_1234_56AA);
        check_eq("pw N+4 syn", 64'(tb_syn(ram_data)), 64'd0);
        check_eq("pw N+4 par", 64'(^ram_data), 64'd0);
        check_eq("pw N+4 ready", 64'(req_ready), 64'd0);
        tick();
        check_eq("pw N+5 ready/en", 64'({req_ready, ram_en}), 64'd2);

        // Clean read back of merged word
        run_rmw(1'b0, 16'd7, 32'h0, 32'h0);
        check_eq("rd valid", 64'(rd_valid), 64'd1);
        check_eq("rd data", 64'(rd_data), 64'h0000_0000_1234_56AA);
        check_eq("rd errs", 64'({sec_err, ded_err}), 64'd0);
        tick();
        check_eq("rd after valid/ready", 64'({rd_valid, req_ready}), 64'd1);

        // Single error on codeword bit 3
        flip = 39'h8;
        run_rmw(1'b0, 16'd5, 32'h0, 32'h0);
        check_eq("sec valid", 64'(rd_valid), 64'd1);
        check_eq("sec data", 64'(rd_data), 64'h0000_0000_DEAD_BEEF);
        check_eq("sec errs", 64'({sec_err, ded_err}), 64'd2);
        tick();
        check_eq("sec cnt", 64'(sec_cnt), 64'd1);
        check_eq("sec pulse gone", 64'(sec_err), 64'd0);

        // Error in overall parity bit only
        flip = 39'd1 << 38;
        run_rmw(1'b0, 16'd5, 32'h0, 32'h0);
        check_eq("par data", 64'(rd_data), 64'h0000_0000_DEAD_BEEF);
        check_eq("par errs", 64'({sec_err, ded_err}), 64'd2);
        tick();
        check_eq("par cnt", 64'(sec_cnt), 64'd2);

        // Double error on read: raw data returned
        flip = (39'd1 << 3) | (39'd1 << 10);
        run_rmw(1'b0, 16'd5, 32'h0, 32'h0);
        check_eq("ded rd valid", 64'(rd_valid), 64'd1);
        check_eq("ded rd data", 64'(rd_data), 64'h0000_0000_DEAD_BAE7);
        check_eq("ded rd errs", 64'({sec_err, ded_err}), 64'd1);
        tick();
        check_eq("ded rd cnt", 64'(sec_cnt), 64'd2);

        // Double error on partial write: aborted
        wcnt0 = wr_cnt;
        run_rmw(1'b1, 16'd5, 32'h0000_FFFF, 32'h0000_FFFF);
        check_eq("ded pw errs", 64'({rd_valid, sec_err, ded_err}), 64'd1);
        tick();
        check_eq("ded pw ready/en", 64'({req_ready, ram_en}), 64'd2);
        tick();
        check_eq("ded pw wr_cnt", 64'(wr_cnt), 64'(wcnt0));

        // Reset during RD_WAIT of a partial write
        flip  = '0;
        wcnt0 = wr_cnt;
        set_req(1'b1, 16'd7, 32'h0, 32'h0000_00FF);
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("midrst ready", 64'(req_ready), 64'd1);
        repeat (4) tick();
        check_eq("midrst wr_cnt", 64'(wr_cnt), 64'(wcnt0));
        check_eq("midrst idle", 64'({req_ready, ram_en}), 64'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
